ascon_perm_ctrl: RTL and testbench

Round-sequencing controller for the Ascon permutation. It accepts a 320-bit state and a round count, then runs one full round per clock: constant addition, the existing `sub_layer_hw` substitution layer, and linear diffusion. It returns the permuted state with a done pulse. It sits between the mode-level controller (init/AD/finalization) and the combinational round datapath.

---
 rtl/ascon_pkg.sv | 45 ++++
 rtl/lin_layer_hw.sv | 24 ++
 rtl/sub_layer_hw.sv | 45 ++++
 rtl/ascon_perm_ctrl.sv | 151 +++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, constants and helpers for the Ascon permutation
package ascon_pkg;

    // Largest legal round count; also the base for the round-constant index.
    localparam int unsigned MAX_ROUNDS_DEF = 12;

    // Right-rotation amounts of the linear diffusion layer, two per word.
    localparam int unsigned ROT_X0_A = 19;
    localparam int unsigned ROT_X0_B = 28;
    localparam int unsigned ROT_X1_A = 61;
    localparam int unsigned ROT_X1_B = 39;
    localparam int unsigned ROT_X2_A = 1;
    localparam int unsigned ROT_X2_B = 6;
    localparam int unsigned ROT_X3_A = 10;
    localparam int unsigned ROT_X3_B = 17;
    localparam int unsigned ROT_X4_A = 7;
    localparam int unsigned ROT_X4_B = 41;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        PERM_IDLE = 2'd0,
        PERM_RUN  = 2'd1,
        PERM_DONE = 2'd2
    } perm_state_e;

    // Round constant for round index idx: high nibble counts down from F,
    // low nibble counts up from 0 (idx 0 -> 0xF0, idx 11 -> 0x4B).
    function automatic logic [63:0] rc(input logic [3:0] idx);
        logic [3:0] hi;
        hi = 4'hF - idx;
        return {56'b0, hi, idx};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/lin_layer_hw.sv
// rtl/lin_layer_hw.sv - Ascon linear diffusion layer
// Ports: x0_i..x4_i state words in, x0_o..x4_o diffused words out (combinational).
module lin_layer_hw
    import ascon_pkg::*;
(
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);

    assign x0_o = x0_i ^ ror64(x0_i, ROT_X0_A) ^ ror64(x0_i, ROT_X0_B);
    assign x1_o = x1_i ^ ror64(x1_i, ROT_X1_A) ^ ror64(x1_i, ROT_X1_B);
    assign x2_o = x2_i ^ ror64(x2_i, ROT_X2_A) ^ ror64(x2_i, ROT_X2_B);
    assign x3_o = x3_i ^ ror64(x3_i, ROT_X3_A) ^ ror64(x3_i, ROT_X3_B);
    assign x4_o = x4_i ^ ror64(x4_i, ROT_X4_A) ^ ror64(x4_i, ROT_X4_B);

endmodule

// File: rtl/sub_layer_hw.sv
// rtl/sub_layer_hw.sv - bitsliced Ascon 5-bit S-box over all 64 columns
// Ports: x0_i..x4_i state words in, x0_o..x4_o substituted words out (combinational).
module sub_layer_hw (
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);

    logic [63:0] a0, a2, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;

    // Input whitening
    assign a0 = x0_i ^ x4_i;
    assign a4 = x4_i ^ x3_i;
    assign a2 = x2_i ^ x1_i;

    // Chi-like nonlinear core
    assign t0 = ~a0   & x1_i;
    assign t1 = ~x1_i & a2;
    assign t2 = ~a2   & x3_i;
    assign t3 = ~x3_i & a4;
    assign t4 = ~a4   & a0;

    assign b0 = a0   ^ t1;
    assign b1 = x1_i ^ t2;
    assign b2 = a2   ^ t3;
    assign b3 = x3_i ^ t4;
    assign b4 = a4   ^ t0;

    // Output mixing
    assign x1_o = b1 ^ b0;
    assign x0_o = b0 ^ b4;
    assign x3_o = b3 ^ b2;
    assign x2_o = ~b2;
    assign x4_o = b4;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - round-sequencing controller for the Ascon permutation
// Ports: clk_i, rst_i (sync, active-high); start_i/rounds_i/x0_i..x4_i request;
//        ready_o, busy_o, done_o, err_o status; x0_o..x4_o state register.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = MAX_ROUNDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  rounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);

    perm_state_e  state_q, state_d;
    ascon_state_t st_q;
    ascon_state_t rnd_in;
    ascon_state_t sub_out;
    ascon_state_t lin_out;
    logic [3:0]   idx_q;
    logic [3:0]   cnt_q;
    logic         err_q;
    logic         rounds_ok;
    logic         load;
    logic         advance;
    logic         reject;

    assign rounds_ok = (rounds_i != 4'd0) && (rounds_i <= 4'(MAX_ROUNDS));

    // Next-state and outputs
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        reject  = 1'b0;
        unique case (state_q)
            PERM_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    if (rounds_ok) begin
                        load    = 1'b1;
                        state_d = PERM_RUN;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            PERM_RUN: begin
                busy_o  = 1'b1;
                advance = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = PERM_DONE;
                end
            end
            PERM_DONE: begin
                done_o  = 1'b1;
                state_d = PERM_IDLE;
            end
            default: begin
                state_d = PERM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PERM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Constant addition feeds the combinational round datapath.
    always_comb begin
        rnd_in    = st_q;
        rnd_in.x2 = st_q.x2 ^ rc(idx_q);
    end

    sub_layer_hw u_sub (
        .x0_i (rnd_in.x0),
        .x1_i (rnd_in.x1),
        .x2_i (rnd_in.x2),
        .x3_i (rnd_in.x3),
        .x4_i (rnd_in.x4),
        .x0_o (sub_out.x0),
        .x1_o (sub_out.x1),
        .x2_o (sub_out.x2),
        .x3_o (sub_out.x3),
        .x4_o (sub_out.x4)
    );

    lin_layer_hw u_lin (
        .x0_i (sub_out.x0),
        .x1_i (sub_out.x1),
        .x2_i (sub_out.x2),
        .x3_i (sub_out.x3),
        .x4_i (sub_out.x4),
        .x0_o (lin_out.x0),
        .x1_o (lin_out.x1),
        .x2_o (lin_out.x2),
        .x3_o (lin_out.x3),
        .x4_o (lin_out.x4)
    );

    // State register, round index and round counter. A short permutation
    // starts its index later so it always ends on the last constant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q  <= '0;
            idx_q <= 4'd0;
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= reject;
            if (load) begin
                st_q  <= '{x0: x0_i, x1: x1_i, x2: x2_i, x3: x3_i, x4: x4_i};
                idx_q <= 4'(MAX_ROUNDS) - rounds_i;
                cnt_q <= rounds_i;
            end else if (advance) begin
                st_q  <= lin_out;
                idx_q <= idx_q + 4'd1;
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign err_o = err_q;
    assign x0_o  = st_q.x0;
    assign x1_o  = st_q.x1;
    assign x2_o  = st_q.x2;
    assign x3_o  = st_q.x3;
    assign x4_o  = st_q.x4;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - self-checking bench for ascon_perm_ctrl
module tb_ascon_perm_ctrl;

    typedef logic [4:0][63:0] st_t;

    // Ascon 5-bit S-box table; input/output bit 4 is word x0, bit 0 is word x4.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  rounds = 4'd0;
    st_t         xin = '0;
    logic        ready_o, busy_o, done_o, err_o;
    logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state
    st_t m_x     = '0;
    int  m_left  = 0;
    int  m_ridx  = 0;
    bit  m_done  = 1'b0;
    bit  m_err   = 1'b0;

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.MAX_ROUNDS(12)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .rounds_i (rounds),
        .x0_i     (xin[0]),
        .x1_i     (xin[1]),
        .x2_i     (xin[2]),
        .x3_i     (xin[3]),
        .x4_i     (xin[4]),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .x0_o     (x0_o),
        .x1_o     (x1_o),
        .x2_o     (x2_o),
        .x3_o     (x3_o),
        .x4_o     (x4_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic int m_rc(input int i);
        return (15 - i) * 16 + i;
    endfunction

    function automatic st_t m_round(input st_t s, input int ridx);
        st_t        t;
        logic [4:0] col;
        logic [4:0] o;
        s[2] = s[2] ^ 64'(m_rc(ridx));
        for (int j = 0; j < 64; j++) begin
            col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o   = SBOX[col];
            t[0][j] = o[4];
            t[1][j] = o[3];
            t[2][j] = o[2];
            t[3][j] = o[1];
            t[4][j] = o[0];
        end
        t[0] = t[0] ^ m_ror(t[0], 19) ^ m_ror(t[0], 28);
        t[1] = t[1] ^ m_ror(t[1], 61) ^ m_ror(t[1], 39);
        t[2] = t[2] ^ m_ror(t[2], 1)  ^ m_ror(t[2], 6);
        t[3] = t[3] ^ m_ror(t[3], 10) ^ m_ror(t[3], 17);
        t[4] = t[4] ^ m_ror(t[4], 7)  ^ m_ror(t[4], 41);
        return t;
    endfunction

    function automatic st_t m_perm(input st_t s, input int r);
        for (int k = 0; k < r; k++) s = m_round(s, 12 - r + k);
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs applied at that edge.
    task automatic model_edge();
        bit was_done;
        if (rst) begin
            m_x = '0; m_left = 0; m_ridx = 0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            was_done = m_done;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_left > 0) begin
                m_x = m_round(m_x, m_ridx);
                m_ridx++;
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (!was_done && start) begin
                if (int'(rounds) >= 1 && int'(rounds) <= 12) begin
                    m_x    = xin;
                    m_ridx = 12 - int'(rounds);
                    m_left = int'(rounds);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(ready_o), 64'(m_left == 0 && !m_done));
            check("busy",  64'(busy_o),  64'(m_left > 0));
            check("done",  64'(done_o),  64'(m_done));
            check("err",   64'(err_o),   64'(m_err));
            check("x0", x0_o, m_x[0]);
            check("x1", x1_o, m_x[1]);
            check("x2", x2_o, m_x[2]);
            check("x3", x3_o, m_x[3]);
            check("x4", x4_o, m_x[4]);
        end
    end

    function automatic st_t rand_state();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    // Start a permutation and return the start-to-done latency in cycles.
    task automatic run_perm(input logic [3:0] r, input st_t s, input bit noise, output int lat);
        rounds = r;
        xin    = s;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 0;
        while (!done_o && lat < 20) begin
            if (noise) begin
                start  = 1'b1;
                rounds = 4'($urandom_range(1, 12));
                xin    = rand_state();
            end
            step();
            start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        st_t z;
        st_t p;
        st_t iv;
        st_t s;
        int  lat;
        int  idx;

        // Model pins: round constants and a hand-computed single round
        idx = 0;  check("rc0",  64'(m_rc(idx)), 64'hF0);
        idx = 11; check("rc11", 64'(m_rc(idx)), 64'h4B);
        idx = 6;  check("rc6",  64'(m_rc(idx)), 64'h96);
        idx = 4;  check("rc4",  64'(m_rc(idx)), 64'hB4);
        z = '0;
        p = m_perm(z, 1);
        check("pin_x0", p[0], 64'h000964B00000004B);
        check("pin_x1", p[1], 64'h0000000096000213);
        check("pin_x2", p[2], 64'h53FFFFFFFFFFFF90);
        check("pin_x3", p[3], 64'h12E580000000004B);
        check("pin_x4", p[4], 64'h0);

        // Reset then idle
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (3) begin
            step();
            check("rst_ready", 64'(ready_o), 64'd1);
            check("rst_x2", x2_o, 64'd0);
        end

        // One round on the all-zero state
        run_perm(4'd1, '0, 1'b0, lat);
        check("lat1", 64'(lat), 64'd1);
        check("r1_x0", x0_o, 64'h000964B00000004B);
        check("r1_x1", x1_o, 64'h0000000096000213);
        check("r1_x2", x2_o, 64'h53FFFFFFFFFFFF90);
        check("r1_x3", x3_o, 64'h12E580000000004B);
        check("r1_x4", x4_o, 64'h0);
        step();
        check("r1_ready", 64'(ready_o), 64'd1);

        // p^12 on the Ascon-128 IV state
        iv = '0;
        iv[0] = 64'h80400c0600000000;
        run_perm(4'd12, iv, 1'b0, lat);
        check("lat12", 64'(lat), 64'd12);
        p = m_perm(iv, 12);
        check("p12_x0", x0_o, p[0]);
        check("p12_x4", x4_o, p[4]);
        step();

        // p^6 and p^8
        s = rand_state();
        run_perm(4'd6, s, 1'b0, lat);
        check("lat6", 64'(lat), 64'd6);
        p = m_perm(s, 6);
        check("p6_x2", x2_o, p[2]);
        step();
        s = rand_state();
        run_perm(4'd8, s, 1'b0, lat);
        check("lat8", 64'(lat), 64'd8);
        p = m_perm(s, 8);
        check("p8_x3", x3_o, p[3]);
        step();

        // Illegal round counts
        rounds = 4'd0; xin = rand_state(); start = 1'b1; step();
        start = 1'b0;
        check("err0", 64'(err_o), 64'd1);
        check("err0_ready", 64'(ready_o), 64'd1);
        step();
        rounds = 4'd13; xin = rand_state(); start = 1'b1; step();
        start = 1'b0;
        check("err13", 64'(err_o), 64'd1);
        check("err13_x3", x3_o, p[3]);
        step();

        // Start re-pulsed during RUN has no effect
        s = rand_state();
        run_perm(4'd12, s, 1'b1, lat);
        check("lat12n", 64'(lat), 64'd12);
        p = m_perm(s, 12);
        check("p12n_x1", x1_o, p[1]);
        step();

        // Reset in the middle of a 12-round run
        run_perm(4'd12, rand_state(), 1'b0, lat);
        step();
        rounds = 4'd12; xin = rand_state(); start = 1'b1; step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_ready", 64'(ready_o), 64'd1);
        check("mid_done", 64'(done_o), 64'd0);
        check("mid_x0", x0_o, 64'd0);
        repeat (3) step();
        s = rand_state();
        run_perm(4'd12, s, 1'b0, lat);
        check("mid_lat", 64'(lat), 64'd12);
        p = m_perm(s, 12);
        check("mid_x4", x4_o, p[4]);
        step();

        // Randomized traffic, including illegal counts, noise starts and resets
        for (int c = 0; c < 1500; c++) begin
            start  = ($urandom_range(0, 3) == 0);
            rounds = 4'($urandom_range(0, 15));
            xin    = rand_state();
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (16) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
